// File: rtl/multi_ch_clk_divider.sv
// rtl/multi_ch_clk_divider.sv - NUM_CH programmable period/high-time clock dividers with ticks
// Config writes land in a pending pair that is promoted only at a period boundary, sync or while disabled.
module multi_ch_clk_divider #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 12,
    parameter int DEF_DIV  = 2,
    parameter int DEF_HIGH = 1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic [CNT_W-1:0] cnt_q       [NUM_CH];
    logic [CNT_W-1:0] cnt_d       [NUM_CH];
    logic [CNT_W-1:0] act_div_q   [NUM_CH];
    logic [CNT_W-1:0] act_div_d   [NUM_CH];
    logic [CNT_W-1:0] act_high_q  [NUM_CH];
    logic [CNT_W-1:0] act_high_d  [NUM_CH];
    logic [CNT_W-1:0] pend_div_q  [NUM_CH];
    logic [CNT_W-1:0] pend_div_d  [NUM_CH];
    logic [CNT_W-1:0] pend_high_q [NUM_CH];
    logic [CNT_W-1:0] pend_high_d [NUM_CH];

    logic [NUM_CH-1:0] run_q;
    logic [NUM_CH-1:0] run_d;
    logic [NUM_CH-1:0] pending_d;
    logic [NUM_CH-1:0] clk_d;
    logic [NUM_CH-1:0] tick_d;
    logic [NUM_CH-1:0] wrap;
    logic [NUM_CH-1:0] restart;
    logic [NUM_CH-1:0] apply;
    logic [NUM_CH-1:0] wr_hit;

    logic [CNT_W-1:0] wr_div;

    // Periods below 2 would make the boundary compare underflow, so clamp at the write port.
    assign wr_div = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

    always_comb begin
        run_d     = run_q;
        pending_d = cfg_pending;
        clk_d     = '0;
        tick_d    = '0;
        wrap      = '0;
        restart   = '0;
        apply     = '0;
        wr_hit    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]       = cnt_q[i];
            act_div_d[i]   = act_div_q[i];
            act_high_d[i]  = act_high_q[i];
            pend_div_d[i]  = pend_div_q[i];
            pend_high_d[i] = pend_high_q[i];

            wr_hit[i]  = cfg_wr && (cfg_ch == CH_W'(i));
            wrap[i]    = run_q[i] && (cnt_q[i] == act_div_q[i] - CNT_W'(1));
            restart[i] = en[i] && (sync || !run_q[i]);
            // Promotion uses the pending state from before this edge, so a
            // write landing on a boundary waits for the next one.
            apply[i]   = cfg_pending[i] && (!en[i] || restart[i] || wrap[i]);

            if (apply[i]) begin
                act_div_d[i]  = pend_div_q[i];
                act_high_d[i] = pend_high_q[i];
                pending_d[i]  = 1'b0;
            end
            if (wr_hit[i]) begin
                pend_div_d[i]  = wr_div;
                pend_high_d[i] = cfg_high;
                pending_d[i]   = 1'b1;
            end

            if (!en[i]) begin
                run_d[i] = 1'b0;
                cnt_d[i] = '0;
            end else if (restart[i] || wrap[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            clk_d[i]  = run_d[i] && (cnt_d[i] < act_high_d[i]);
            tick_d[i] = run_d[i] && (cnt_d[i] == '0);
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]       <= '0;
                act_div_q[i]   <= CNT_W'(DEF_DIV);
                act_high_q[i]  <= CNT_W'(DEF_HIGH);
                pend_div_q[i]  <= CNT_W'(DEF_DIV);
                pend_high_q[i] <= CNT_W'(DEF_HIGH);
            end
            run_q       <= '0;
            cfg_pending <= '0;
            clk_out     <= '0;
            tick        <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]       <= cnt_d[i];
                act_div_q[i]   <= act_div_d[i];
                act_high_q[i]  <= act_high_d[i];
                pend_div_q[i]  <= pend_div_d[i];
                pend_high_q[i] <= pend_high_d[i];
            end
            run_q       <= run_d;
            cfg_pending <= pending_d;
            clk_out     <= clk_d;
            tick        <= tick_d;
        end
    end

endmodule

// File: tb/tb_multi_ch_clk_divider.sv
// tb/tb_multi_ch_clk_divider.sv - directed self-checking bench for multi_ch_clk_divider
module tb_multi_ch_clk_divider;

    localparam int NCH = 3;
    localparam int CW  = 12;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] en;
    logic           sync;
    logic           cfg_wr;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic [CW-1:0]  cfg_high;
    logic [NCH-1:0] cfg_pending;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;

    int n_checks = 0;
    int n_fail   = 0;

    multi_ch_clk_divider #(
        .NUM_CH(NCH), .CNT_W(CW), .DEF_DIV(2), .DEF_HIGH(1)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .cfg_pending(cfg_pending), .clk_out(clk_out), .tick(tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each running channel remembers the cycle its current period began;
    // position in the period is simply "now - start".
    int             m_cyc = 0;
    bit             m_run   [NCH];
    int             m_start [NCH];
    int             m_div   [NCH];
    int             m_high  [NCH];
    int             m_pdiv  [NCH];
    int             m_phigh [NCH];
    bit             m_pnd   [NCH];
    bit             m_end, m_restart, m_apply;
    logic [NCH-1:0] exp_clk, exp_tick, exp_pnd;

    always @(posedge clk_in) begin
        m_cyc++;
        for (int i = 0; i < NCH; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_div[i] = 2; m_high[i] = 1;
                m_pdiv[i] = 2; m_phigh[i] = 1; m_pnd[i] = 0;
            end else begin
                m_end     = m_run[i] && (m_cyc - m_start[i] == m_div[i]);
                m_restart = en[i] && (sync || !m_run[i]);
                m_apply   = m_pnd[i] && (!en[i] || m_restart || m_end);
                if (m_apply) begin
                    m_div[i] = m_pdiv[i]; m_high[i] = m_phigh[i]; m_pnd[i] = 0;
                end
                if (cfg_wr && cfg_ch == i) begin
                    m_pdiv[i]  = (cfg_div < 2) ? 2 : int'(cfg_div);
                    m_phigh[i] = int'(cfg_high);
                    m_pnd[i]   = 1;
                end
                if (!en[i]) m_run[i] = 0;
                else if (m_restart || m_end) begin
                    m_run[i] = 1; m_start[i] = m_cyc;
                end
            end
            exp_clk[i]  = m_run[i] && (m_cyc - m_start[i] < m_high[i]);
            exp_tick[i] = m_run[i] && (m_cyc == m_start[i]);
            exp_pnd[i]  = m_pnd[i];
        end
        #1;
        check("model clk_out", 32'(clk_out), 32'(exp_clk));
        check("model tick", 32'(tick), 32'(exp_tick));
        check("model cfg_pending", 32'(cfg_pending), 32'(exp_pnd));
    end

    logic [NCH-1:0] ck_h [32];
    logic [NCH-1:0] tk_h [32];
    logic [NCH-1:0] pd_h [32];

    task automatic rec(input int j);
        @(posedge clk_in); #2;
        ck_h[j] = clk_out; tk_h[j] = tick; pd_h[j] = cfg_pending;
    endtask

    task automatic run(input int n);
        for (int j = 0; j < n; j++) rec(j);
    endtask

    function automatic logic [31:0] hist(input int kind, input int ch, input int n);
        logic [31:0] v = '0;
        for (int j = 0; j < n; j++)
            v = {v[30:0], (kind == 0) ? ck_h[j][ch] : (kind == 1) ? tk_h[j][ch] : pd_h[j][ch]};
        return v;
    endfunction

    // Disable, write config (applied while disabled), then re-enable.
    task automatic prog(input int ch, input int d, input int h);
        @(negedge clk_in); en[ch] = 1'b0; cfg_wr = 1'b1; cfg_ch = 2'(ch);
        cfg_div = CW'(d); cfg_high = CW'(h);
        @(negedge clk_in); cfg_wr = 1'b0;
        @(negedge clk_in); en[ch] = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = '0; sync = 1'b0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_div = '0; cfg_high = '0;
        repeat (2) @(posedge clk_in);
        #2;
        check("reset clk_out", 32'(clk_out), 0);
        check("reset tick", 32'(tick), 0);
        check("reset pending", 32'(cfg_pending), 0);

        @(negedge clk_in); rst_n = 1'b1; en = 3'b001;
        run(6);
        check("default clk0", hist(0, 0, 6), 32'b101010);
        check("default tick0", hist(1, 0, 6), 32'b101010);

        prog(1, 5, 2); run(10);
        check("div5 high2 clk1", hist(0, 1, 10), 32'b1100011000);
        check("div5 high2 tick1", hist(1, 1, 10), 32'b1000010000);
        prog(1, 5, 3); run(10);
        check("div5 high3 clk1", hist(0, 1, 10), 32'b1110011100);

        prog(0, 4, 2);
        for (int j = 0; j < 20; j++) begin
            rec(j);
            @(negedge clk_in);
            cfg_wr = (j == 1 || j == 9); cfg_ch = 2'd0;
            cfg_div = (j == 1) ? CW'(6) : CW'(3);
            cfg_high = (j == 1) ? CW'(3) : CW'(1);
        end
        check("reload clk0", hist(0, 0, 20), 32'b1100_1110_0011_1000_1001);
        check("reload tick0", hist(1, 0, 20), 32'b1000_1000_0010_0000_1001);
        check("reload pending0", hist(2, 0, 20), 32'b0011_0000_0011_1111_0000);

        prog(2, 1, 1); run(6);
        check("div1 clamp clk2", hist(0, 2, 6), 32'b101010);
        prog(2, 4, 0); run(8);
        check("high0 clk2", hist(0, 2, 8), 32'b0);
        check("high0 tick2", hist(1, 2, 8), 32'b10001000);
        prog(2, 5, 7); run(10);
        check("high>div clk2", hist(0, 2, 10), 32'b1111111111);
        check("high>div tick2", hist(1, 2, 10), 32'b1000010000);
        @(negedge clk_in); en[2] = 1'b0;

        prog(0, 3, 1); prog(1, 4, 2); run(2);
        @(negedge clk_in); sync = 1'b1;
        for (int j = 0; j < 6; j++) begin
            rec(j);
            @(negedge clk_in); sync = 1'b0;
        end
        check("sync clk0", hist(0, 0, 6), 32'b100100);
        check("sync tick0", hist(1, 0, 6), 32'b100100);
        check("sync clk1", hist(0, 1, 6), 32'b110011);
        check("sync tick1", hist(1, 1, 6), 32'b100010);
        check("sync disabled clk2", hist(0, 2, 6), 32'b0);

        run(3);
        @(negedge clk_in); en[1] = 1'b0;
        run(1);
        check("abort clk1", 32'(ck_h[0][1]), 0);
        check("abort tick1", 32'(tk_h[0][1]), 0);

        @(negedge clk_in); cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(7); cfg_high = CW'(3);
        run(1);
        check("pending before reset", 32'(pd_h[0][0]), 1);
        @(negedge clk_in); cfg_wr = 1'b0; rst_n = 1'b0;
        run(1);
        check("mid reset clk_out", 32'(ck_h[0]), 0);
        check("mid reset pending", 32'(pd_h[0]), 0);
        @(negedge clk_in); rst_n = 1'b1;
        run(4);
        check("post reset clk0", hist(0, 0, 4), 32'b1010);
        check("post reset pending0", hist(2, 0, 4), 32'b0);

        @(negedge clk_in); cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_div = CW'(9); cfg_high = CW'(9);
        run(1);
        @(negedge clk_in); cfg_wr = 1'b0;
        run(4);
        check("illegal write pending", {20'b0, pd_h[0], pd_h[1], pd_h[2], pd_h[3]}, 32'b0);
        check("illegal write clk0", hist(0, 0, 4), 32'b0101);

        repeat (2) @(posedge clk_in);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multi_ch_clk_divider.md
# multi_ch_clk_divider

Parametrised, multi-channel successor to the single odd/even clock divider. It generates NUM_CH independent divided clock outputs and period ticks from one clock, using only rising edges. Each channel has a runtime-programmable period and high time, so any duty cycle is possible for odd or even divisors. Reloads are glitch-free and take effect only at a period boundary. The block feeds the PWM stages and any logic that needs a slow clock-enable.

## Interface
- NUM_CH, 4: number of channels (1..16).
- CNT_W, 12: width of the period counter and the config fields.
- DEF_DIV, 2: per-channel period after reset (>=2).
- DEF_HIGH, 1: per-channel high time after reset.
- CH_W, max(1, clog2(NUM_CH)): channel-select width (derived).

- clk_in  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle pulse; restarts all enabled channels in phase.
- cfg_wr  in  1  config write strobe.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_div  in  CNT_W  new period, in clk_in cycles.
- cfg_high  in  CNT_W  new high time, in clk_in cycles.
- cfg_pending  out  NUM_CH  a written config is waiting for this channel's boundary.
- clk_out  out  NUM_CH  divided clock, registered.
- tick  out  NUM_CH  one-cycle pulse in the first cycle of every period, registered.

## Operation
- Per-channel state:
  - cnt[CNT_W]: index of the current cycle in the period.
  - run flag.
  - active pair act_div/act_high.
  - pending pair pend_div/pend_high plus the cfg_pending bit.
- Output rule: in any cycle where run=1 and cnt=k, clk_out = (k < act_high) and tick = (k == 0). Both outputs are registers computed from next-state values, so there is no combinational path to the outputs.
- Write handling:
  - On cfg_wr with cfg_ch < NUM_CH: the pending pair is loaded and cfg_pending set.
  - cfg_div < 2 is stored as 2.
  - Last write before a boundary wins.
  - cfg_ch >= NUM_CH: the write is ignored.
- Counting: while run=1, cnt increments each cycle. When cnt = act_div-1 (the boundary), cnt goes to 0.
- At a boundary with cfg_pending=1: act <= pend and cfg_pending clears.
  - A write in the boundary cycle itself is not bypassed. It stays pending and is applied at the following boundary.
- Duty rules:
  - act_high = 0: clk_out is constantly 0.
  - act_high >= act_div: clk_out is constantly 1.
  - tick still pulses once per period in both cases.
- en low:
  - run=0, cnt=0, clk_out=0, tick=0.
  - A pending config is applied immediately (next edge) while disabled.
- en rising: at the edge where en=1 is sampled with run=0, the channel sets run=1 and cnt=0. tick=1 and clk_out=(0<act_high) in the next cycle.
- sync: at the edge where sync=1, every channel with en=1 sets cnt=0 and tick=1, and applies any pending config as if at a boundary.
  - sync overrides a coincident wrap.
  - Disabled channels ignore sync.
- Width rule: cnt compares against act_div-1 in CNT_W bits. act_div >= 2 always holds, so there is no underflow.

## Timing
- Reset values, at the first edge with rst_n=0:
  - cnt=0, run=0, clk_out=0, tick=0, cfg_pending=0.
  - act_div=DEF_DIV, act_high=DEF_HIGH.
  - Pending pair = DEF_DIV/DEF_HIGH.
- rst_n low mid-operation: all of the above take effect on the next edge, discarding pending writes.
- Latency:
  - en or sync to first tick: 1 cycle.
  - cfg_wr to cfg_pending: 1 cycle.
  - Pending to active: the edge that ends the current period.
- Steady state: tick period = act_div cycles exactly, with clk_out high for min(act_high, act_div) consecutive cycles starting at the tick cycle.
- Channels are fully independent except for the shared sync input and the shared write port.

## Test plan
- Reset and default:
  - Hold rst_n=0 for 2 cycles: clk_out=0, tick=0, cfg_pending=0.
  - Release with en[0]=1: clk_out[0] is 1,0,1,0…; tick[0] every 2 cycles; first tick 1 cycle after en is sampled.
- Odd divisor:
  - Write ch1 div=5 high=2, then en[1]=1: clk_out[1] is 1,1,0,0,0 repeating; tick[1] every 5 cycles.
  - Repeat with high=3: pattern 1,1,1,0,0.
- Glitch-free reload:
  - ch0 running div=4 high=2; at cnt=1 write div=6 high=3.
  - cfg_pending[0]=1; the current period finishes 1,1,0,0.
  - The next period is 1,1,1,0,0,0; cfg_pending clears at that boundary.
  - A write in the boundary cycle is applied one period later.
- Clamps:
  - div=1 behaves as div=2.
  - high=0 gives constant 0 with ticks every period.
  - div=5 high=7 gives constant 1 with ticks every 5 cycles.
- sync:
  - ch0 div=3 and ch1 div=4 running out of phase; pulse sync.
  - Both tick in the same next cycle and both restart their patterns.
  - A disabled ch2 stays 0.
- Abort and illegal writes:
  - Drop en[1] mid-period: outputs are 0 next cycle.
  - Pulse rst_n=0 mid-period with a pending write: everything returns to defaults.
  - A write with cfg_ch=NUM_CH changes nothing.
